// File: rtl/scaler_pkg.sv
// Fixed-point constants and helpers shared by the scaler_v / scaler_h chain.
package scaler_pkg;

    localparam int unsigned STEP_FRAC    = 12;
    localparam int unsigned LINE_STEP    = 1 << STEP_FRAC;
    localparam logic [15:0] LINE_STEP_16 = 16'(LINE_STEP);

    typedef enum logic [1:0] {StIdle, StFirst, StRun} scaler_h_state_e;

    // Upscaling is not supported; anything finer than 1:1 degrades to bypass.
    function automatic logic [15:0] clamp_step(input logic [15:0] step);
        return (step < LINE_STEP_16) ? LINE_STEP_16 : step;
    endfunction

endpackage

// File: rtl/scaler_h_if.sv
// Pixel stream and line configuration between the horizontal scaler and its neighbours.
interface scaler_h_if #(
    parameter int unsigned PIXEL_WIDTH = 8
);
    logic [15:0]            line_in_size;
    logic [15:0]            scale_step;
    logic [PIXEL_WIDTH-1:0] di_i;
    logic                   de_i;
    logic                   hs_i;
    logic                   vs_i;
    logic [PIXEL_WIDTH-1:0] do_o;
    logic                   de_o;
    logic                   hs_o;
    logic                   vs_o;

    modport master (
        output line_in_size, scale_step, di_i, de_i, hs_i, vs_i,
        input  do_o, de_o, hs_o, vs_o
    );

    modport slave (
        input  line_in_size, scale_step, di_i, de_i, hs_i, vs_i,
        output do_o, de_o, hs_o, vs_o
    );
endinterface

// File: rtl/scaler_h_interp.sv
// Two-stage linear interpolator: weighted sum with half-up rounding, then output register.
module scaler_h_interp
    import scaler_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_vld,
    input  logic                   i_hs,
    input  logic                   i_vs,
    input  logic [PIXEL_WIDTH-1:0] i_prev,
    input  logic [PIXEL_WIDTH-1:0] i_cur,
    input  logic [STEP_FRAC-1:0]   i_frac,
    output logic [PIXEL_WIDTH-1:0] o_pix,
    output logic                   o_vld,
    output logic                   o_hs,
    output logic                   o_vs
);
    localparam int unsigned SumW = PIXEL_WIDTH + STEP_FRAC + 1;

    logic [SumW-1:0] w_sum;
    logic [SumW-1:0] r_sum;
    logic            r_vld;
    logic            r_hs;
    logic            r_vs;

    // Weights sum to LINE_STEP, so the shifted result always fits the pixel range.
    always_comb begin
        w_sum = SumW'(i_prev) * (SumW'(LINE_STEP) - SumW'(i_frac))
              + SumW'(i_cur) * SumW'(i_frac)
              + SumW'(LINE_STEP / 2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
            r_vld <= 1'b0;
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
            o_pix <= '0;
            o_vld <= 1'b0;
            o_hs  <= 1'b0;
            o_vs  <= 1'b0;
        end else begin
            r_vld <= i_vld;
            r_hs  <= i_vld & i_hs;
            r_vs  <= i_vld & i_vs;
            if (i_vld) begin
                r_sum <= w_sum;
            end
            o_vld <= r_vld;
            o_hs  <= r_hs;
            o_vs  <= r_vs;
            if (r_vld) begin
                o_pix <= PIXEL_WIDTH'(r_sum >> STEP_FRAC);
            end
        end
    end

endmodule

// File: rtl/scaler_h.sv
// Horizontal downscaler: phase accumulator and index counter pick pixel pairs for the
// interpolator; hs/vs are re-attached to the first output pixel of each line.
module scaler_h
    import scaler_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH      = 8,
    parameter int unsigned LINE_IN_SIZE_MAX = 1024
) (
    input logic       clk,
    input logic       rst,
    scaler_h_if.slave bus
);
    localparam int unsigned     IdxW   = $clog2(LINE_IN_SIZE_MAX + 1);
    localparam logic [IdxW-1:0] IdxMax = '1;

    scaler_h_state_e        r_state;
    logic [15:0]            r_step;
    logic [15:0]            r_resid;
    logic [IdxW-1:0]        r_idx;
    logic [PIXEL_WIDTH-1:0] r_prev;
    logic                   r_hs_pend;
    logic                   r_vs_pend;
    logic                   r_cap_vld;
    logic                   r_cap_hs;
    logic                   r_cap_vs;
    logic [PIXEL_WIDTH-1:0] r_cap_prev;
    logic [PIXEL_WIDTH-1:0] r_cap_cur;
    logic [STEP_FRAC-1:0]   r_cap_frac;

    logic        w_hs;
    logic        w_acc;
    logic        w_bypass;
    logic        w_near;
    logic        w_emit;
    logic [15:0] w_step;

    always_comb begin
        w_hs     = bus.de_i & bus.hs_i;
        w_step   = w_hs ? clamp_step(bus.scale_step) : r_step;
        w_bypass = (w_step == LINE_STEP_16);
        w_acc    = bus.de_i & ~bus.hs_i & (r_state != StIdle)
                 & (16'(r_idx) <= bus.line_in_size);
        w_near   = (r_resid < LINE_STEP_16);
        // The line-start pixel only completes a pair in bypass mode.
        w_emit   = w_hs ? w_bypass : (w_acc & (w_bypass | w_near));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_step     <= LINE_STEP_16;
            r_resid    <= '0;
            r_idx      <= '0;
            r_prev     <= '0;
            r_hs_pend  <= 1'b0;
            r_vs_pend  <= 1'b0;
            r_cap_vld  <= 1'b0;
            r_cap_hs   <= 1'b0;
            r_cap_vs   <= 1'b0;
            r_cap_prev <= '0;
            r_cap_cur  <= '0;
            r_cap_frac <= '0;
        end else begin
            r_cap_vld <= w_emit;
            r_cap_hs  <= w_emit & (r_hs_pend | w_hs);
            r_cap_vs  <= w_emit & (r_vs_pend | (w_hs & bus.vs_i));
            if (w_emit) begin
                r_cap_prev <= w_bypass ? bus.di_i : r_prev;
                r_cap_cur  <= bus.di_i;
                r_cap_frac <= w_bypass ? '0 : r_resid[STEP_FRAC-1:0];
            end
            if (w_hs) begin
                r_state   <= StFirst;
                r_step    <= w_step;
                r_idx     <= IdxW'(1);
                r_resid   <= '0;
                r_prev    <= bus.di_i;
                r_hs_pend <= ~w_emit;
                r_vs_pend <= ~w_emit & (r_vs_pend | bus.vs_i);
            end else if (w_acc) begin
                r_state <= StRun;
                r_prev  <= bus.di_i;
                if (r_idx != IdxMax) begin
                    r_idx <= r_idx + 1'b1;
                end
                if (w_near) begin
                    r_resid <= r_resid + r_step - LINE_STEP_16;
                end else begin
                    r_resid <= r_resid - LINE_STEP_16;
                end
                if (w_emit) begin
                    r_hs_pend <= 1'b0;
                    r_vs_pend <= 1'b0;
                end
            end
        end
    end

    scaler_h_interp #(
        .PIXEL_WIDTH(PIXEL_WIDTH)
    ) u_interp (
        .clk   (clk),
        .rst   (rst),
        .i_vld (r_cap_vld),
        .i_hs  (r_cap_hs),
        .i_vs  (r_cap_vs),
        .i_prev(r_cap_prev),
        .i_cur (r_cap_cur),
        .i_frac(r_cap_frac),
        .o_pix (bus.do_o),
        .o_vld (bus.de_o),
        .o_hs  (bus.hs_o),
        .o_vs  (bus.vs_o)
    );

endmodule

// File: tb/tb_scaler_h.sv
// Self-checking bench for scaler_h: vector table of line configurations plus corner sequences.
module tb_scaler_h;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    scaler_h_if #(.PIXEL_WIDTH(8)) bus ();

    scaler_h #(
        .PIXEL_WIDTH     (8),
        .LINE_IN_SIZE_MAX(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] val;
        logic       hs;
        logic       vs;
    } exp_t;

    typedef struct {
        int step;
        int wm1;
        int gap;
        int extra;
        int exp_cnt;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] out_log[$];
    logic [7:0] pix[0:1279];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_out   = 0;
    int         consec  = 0;
    bit         prev_de = 1'b0;
    int         lat_t0  = 0;
    int         lat_meas = -1;
    bit         lat_arm = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Reference: output k sits at position k*step; pixels past the received/allowed width
    // are never used.
    function automatic void push_line(input int weff, input int step, input bit vs);
        int st;
        bit first;
        st = (step < 4096) ? 4096 : step;
        first = 1'b1;
        if (st == 4096) begin
            for (int i = 0; i < weff; i++) begin
                exp_q.push_back('{pix[i], first, first & vs});
                first = 1'b0;
            end
        end else begin
            for (longint pos = 0; pos < longint'(weff - 1) * 4096; pos += st) begin
                int i;
                int f;
                int v;
                i = int'(pos / 4096);
                f = int'(pos % 4096);
                v = (pix[i] * (4096 - f) + pix[i + 1] * f + 2048) / 4096;
                exp_q.push_back('{8'(v), first, first & vs});
                first = 1'b0;
            end
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_line(input int wm1, input int step, input bit vs, input int gap,
                             input int npix, input bit rnd, input int lat_idx);
        int weff;
        for (int i = 0; i < npix; i++) begin
            pix[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1);
        end
        weff = (npix < wm1 + 1) ? npix : wm1 + 1;
        push_line(weff, step, vs);
        bus.line_in_size = 16'(wm1);
        bus.scale_step   = 16'(step);
        for (int i = 0; i < npix; i++) begin
            bus.di_i = pix[i];
            bus.de_i = 1'b1;
            bus.hs_i = (i == 0);
            bus.vs_i = (i == 0) && vs;
            if (i == lat_idx) begin
                lat_t0   = cyc;
                lat_meas = -1;
                lat_arm  = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.de_i = 1'b0;
            bus.hs_i = 1'b0;
            bus.vs_i = 1'b0;
            idle(gap);
        end
    endtask

    task automatic drive_raw(input int n);
        for (int i = 0; i < n; i++) begin
            bus.di_i = 8'(200 + i);
            bus.de_i = 1'b1;
            @(posedge clk);
            #1;
            bus.de_i = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        idle(6);
        check({name, "_drain_missing"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.de_o === 1'b1) begin
                n_out++;
                out_log.push_back(bus.do_o);
                if (prev_de) consec++;
                if (lat_arm) begin
                    lat_meas = cyc - lat_t0;
                    lat_arm  = 1'b0;
                end
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_de_o: got do=%0d hs=%0b vs=%0b, required no output",
                             bus.do_o, bus.hs_o, bus.vs_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.do_o, bus.hs_o, bus.vs_o} !== e) begin
                        n_fail++;
                        $display("FAIL out_pixel: got do=%0d hs=%0b vs=%0b, required do=%0d hs=%0b vs=%0b",
                                 bus.do_o, bus.hs_o, bus.vs_o, e.val, e.hs, e.vs);
                    end
                end
            end
            prev_de = (bus.de_o === 1'b1);
        end
    endtask

    initial begin
        vec_t vecs[11];
        vecs[0]  = '{8192, 255, 0, 0, 128};
        vecs[1]  = '{6144, 255, 0, 0, 170};
        vecs[2]  = '{4096, 255, 0, 0, 256};
        vecs[3]  = '{2048, 255, 0, 0, 256};
        vecs[4]  = '{8192, 255, 3, 0, 128};
        vecs[5]  = '{8192,   0, 0, 2,   0};
        vecs[6]  = '{12288, 255, 0, 4, 85};
        vecs[7]  = '{4096,   9, 0, 5,  10};
        vecs[8]  = '{65535, 255, 1, 0, 16};
        vecs[9]  = '{4097,  99, 0, 3,  99};
        vecs[10] = '{8192,   1, 0, 0,   1};

        bus.line_in_size = 16'd255;
        bus.scale_step   = 16'd4096;
        bus.di_i         = 8'd0;
        bus.de_i         = 1'b0;
        bus.hs_i         = 1'b0;
        bus.vs_i         = 1'b0;
        fork
            monitor();
        join_none

        rst = 1'b1;
        idle(3);
        check("reset_outputs", {bus.do_o, bus.de_o, bus.hs_o, bus.vs_o}, 0);
        rst = 1'b0;
        idle(2);

        foreach (vecs[v]) begin
            n_out  = 0;
            consec = 0;
            send_line(vecs[v].wm1, vecs[v].step, 1'b1, vecs[v].gap,
                      vecs[v].wm1 + 1 + vecs[v].extra, 1'b0, -1);
            idle(3);
            send_line(vecs[v].wm1, vecs[v].step, 1'b0, vecs[v].gap,
                      vecs[v].wm1 + 1 + vecs[v].extra, 1'b1, -1);
            drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d_count", v), n_out, 2 * vecs[v].exp_cnt);
            if (vecs[v].gap > 0) begin
                check($sformatf("vec%0d_no_back_to_back_de_o", v), consec, 0);
            end
        end

        send_line(3, 4096, 1'b1, 0, 4, 1'b1, 0);
        drain("lat_bypass");
        check("latency_bypass", lat_meas, 3);
        send_line(3, 8192, 1'b1, 0, 4, 1'b1, 1);
        drain("lat_down");
        check("latency_downscale", lat_meas, 3);

        // New hs_i arrives right after input pixel 49 of a 256-wide line.
        n_out = 0;
        out_log.delete();
        send_line(255, 8192, 1'b1, 0, 50, 1'b0, -1);
        send_line(255, 8192, 1'b0, 0, 256, 1'b1, -1);
        drain("abort");
        check("abort_count", n_out, 25 + 128);
        if (out_log.size() > 25) begin
            check("abort_restart_value", out_log[25], pix[0]);
        end else begin
            check("abort_restart_present", out_log.size(), 26);
        end

        // Reset in the middle of line 100; pixel 7's output is still in the pipeline.
        n_out = 0;
        for (int l = 0; l < 100; l++) begin
            send_line(15, 8192, l == 0, 0, 16, 1'b0, -1);
            idle(2);
        end
        send_line(15, 8192, 1'b0, 0, 8, 1'b0, -1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midline_reset_outputs", {bus.do_o, bus.de_o, bus.hs_o, bus.vs_o}, 0);
        check("pre_reset_count", n_out, 100 * 8 + 3);
        idle(2);
        rst = 1'b0;
        n_out = 0;
        drive_raw(8);
        idle(5);
        check("post_reset_ignored", n_out, 0);
        send_line(15, 8192, 1'b1, 0, 16, 1'b1, -1);
        drain("post_reset");
        check("post_reset_count", n_out, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

endmodule
